i_fetch: RTL

//  Instruction fetch stage upstream of the 16x8 instruction memory (i_mem). Owns the PC, drives the memory

---
 rtl/i_fetch.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/i_fetch.sv
// Instruction fetch stage: owns the PC, hides the 1-cycle i_mem read latency and feeds a 2-entry queue.
// Optional program loader is compiled in when FETCH_LOADER_EN is defined.
module i_fetch #(
  parameter int                ADDR_W     = 4,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [DATA_W-1:0] imem_din,
  input  logic [DATA_W-1:0] imem_dout,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              running,
  output logic              halted,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALT
`ifdef FETCH_LOADER_EN
    , ST_LOAD
`endif
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]        count_q, count_d;
  entry_t            q_q [2];
  entry_t            q_d [2];

  logic       pop, push, issue, flush, wr_hi;
  logic [2:0] used;

`ifdef FETCH_LOADER_EN
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
`else
  logic unused_load;
  assign unused_load = ^{load_valid, load_data, load_last};
`endif

  assign instr_valid = (count_q != 2'd0);
  assign instr       = q_q[0].data;
  assign instr_pc    = q_q[0].pc;
  assign running     = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);

  assign pop   = instr_valid & instr_ready;
  assign used  = {1'b0, count_q} + {2'b00, inflight_q};
  assign wr_hi = ((count_q - {1'b0, pop}) != 2'd0);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    q_d           = q_q;
    issue         = 1'b0;
    flush         = 1'b0;
    push          = inflight_q;
    imem_addr     = pc_q;
    imem_we       = 1'b0;
    imem_din      = '0;
`ifdef FETCH_LOADER_EN
    load_ptr_d    = load_ptr_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
`ifdef FETCH_LOADER_EN
        if (load_valid) begin
          imem_we    = 1'b1;
          imem_addr  = load_ptr_q;
          imem_din   = load_data;
          load_ptr_d = load_ptr_q + 1'b1;
          state_d    = ST_LOAD;
          if (load_last) begin
            load_ptr_d = '0;
            state_d    = ST_IDLE;
          end
        end else
`endif
        if (start) begin
          state_d = ST_RUN;
          pc_d    = START_ADDR;
        end
      end
`ifdef FETCH_LOADER_EN
      ST_LOAD: begin
        if (load_valid) begin
          imem_we    = 1'b1;
          imem_addr  = load_ptr_q;
          imem_din   = load_data;
          load_ptr_d = load_ptr_q + 1'b1;
          if (load_last) begin
            load_ptr_d = '0;
            state_d    = ST_IDLE;
          end
        end
      end
`endif
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d  = redirect_addr;
          flush = 1'b1;
          if (halt_req) state_d = ST_DRAIN;
        end else if (halt_req) begin
          state_d = ST_DRAIN;
        end else if (used < (3'd2 + {2'b00, pop})) begin
          // Credit: queued + in-flight, less what leaves this cycle, must stay below capacity.
          issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) begin
          pc_d  = redirect_addr;
          flush = 1'b1;
        end else if (count_q == 2'd0 && !inflight_q) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      pc_d          = pc_q + 1'b1;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) q_d[0] = q_q[1];
      if (push) begin
        if (wr_hi) q_d[1] = '{data: imem_dout, pc: inflight_pc_q};
        else       q_d[0] = '{data: imem_dout, pc: inflight_pc_q};
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= START_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      // NOTE: queue storage is reset too, because instr/instr_pc are visible outputs that must read 0.
      q_q[0]        <= '0;
      q_q[1]        <= '0;
`ifdef FETCH_LOADER_EN
      load_ptr_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      q_q           <= q_d;
`ifdef FETCH_LOADER_EN
      load_ptr_q    <= load_ptr_d;
`endif
    end
  end

endmodule
